// File: rtl/bram_stream_reader_pkg.sv
// Shared types and constants for the block-RAM stream reader and its skid FIFO.
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned FifoDepth      = 2;
  localparam int unsigned FifoCountWidth = $clog2(FifoDepth + 1);

endpackage

// File: rtl/bram_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs the RAM read latency under backpressure.
module bram_skid_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned blockLength = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [blockLength-1:0]    pushData,
  input  logic                      pop,
  output logic [blockLength-1:0]    headData,
  output logic [FifoCountWidth-1:0] count
);

  logic [blockLength-1:0]    mem_q [FifoDepth];
  logic                      rd_ptr_q, wr_ptr_q;
  logic [FifoCountWidth-1:0] count_q, count_d;
  logic                      do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && ((count_q != FifoCountWidth'(FifoDepth)) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // One-bit pointers: the depth is fixed at two entries.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= pushData;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign headData = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a wrapping address range of a registered-read block RAM and streams the words out
// on a valid/ready interface, throttled by a credit rule so the skid FIFO never overflows.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned blockLength     = 32,
  parameter int unsigned memDepth        = 64,
  parameter int unsigned addressBitWidth = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [addressBitWidth-1:0] startAddress,
  input  logic [addressBitWidth:0]   wordCount,
  output logic                       busy,
  output logic                       done,
  output logic [addressBitWidth-1:0] ramAddress,
  output logic                       ramWriteEnable,
  input  logic [blockLength-1:0]     ramDataOut,
  output logic [blockLength-1:0]     outData,
  output logic                       outValid,
  input  logic                       outReady
);

  state_e                       state_q, state_d;
  logic [addressBitWidth-1:0]   ram_address_q, ram_address_d, ram_address_next;
  logic [addressBitWidth:0]     word_count_q, word_count_d;
  logic [addressBitWidth:0]     issued_q, issued_d;
  logic                         inflight_q, inflight_d;
  logic                         issue, pop, fifo_empty_next;
  logic [FifoCountWidth-1:0]    fifo_count;
  logic [FifoCountWidth:0]      occupancy;

  assign ramWriteEnable = 1'b0;
  assign ramAddress     = ram_address_q;
  assign outValid       = (fifo_count != '0);
  assign pop            = outValid && outReady;

  // ramAddress is the next word to read; the RAM samples it at the edge where it is issued.
  assign ram_address_next = (ram_address_q == addressBitWidth'(memDepth - 1)) ? '0
                                                                              : ram_address_q + 1'b1;
  assign occupancy        = {1'b0, fifo_count} + (FifoCountWidth + 1)'(inflight_q);
  assign fifo_empty_next  = (fifo_count == '0) ||
                            ((fifo_count == FifoCountWidth'(1)) && pop);

  always_comb begin
    state_d       = state_q;
    ram_address_d = ram_address_q;
    word_count_d  = word_count_q;
    issued_d      = issued_q;
    issue         = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          word_count_d = wordCount;
          issued_d     = '0;
          if (wordCount == '0) begin
            state_d = StDone;
          end else begin
            ram_address_d = startAddress;
            state_d       = StRead;
          end
        end
      end
      StRead: begin
        if ((issued_q < word_count_q) &&
            ((occupancy < (FifoCountWidth + 1)'(FifoDepth)) || pop)) begin
          issue         = 1'b1;
          ram_address_d = ram_address_next;
          issued_d      = issued_q + 1'b1;
          if (issued_d == word_count_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!inflight_q && fifo_empty_next) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign inflight_d = issue;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      ram_address_q <= '0;
      word_count_q  <= '0;
      issued_q      <= '0;
      inflight_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ram_address_q <= ram_address_d;
      word_count_q  <= word_count_d;
      issued_q      <= issued_d;
      inflight_q    <= inflight_d;
    end
  end

  bram_skid_fifo #(
    .blockLength(blockLength)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (inflight_q),
    .pushData(ramDataOut),
    .pop     (pop),
    .headData(outData),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench: registered-read RAM model, table of commands, reset/corner sequences,
// and random commands with random backpressure checked against an address-order model.
module tb_bram_stream_reader;

  localparam int unsigned BL        = 32;
  localparam int unsigned MD        = 64;
  localparam int unsigned AW        = 6;
  localparam int          MaxCycles = 600;
  localparam int          Skip      = -2;

  logic          clock = 1'b0;
  logic          reset, start, busy, done, ramWriteEnable, outValid, outReady;
  logic [AW-1:0] startAddress, ramAddress;
  logic [AW:0]   wordCount;
  logic [BL-1:0] ramDataOut, outData;
  logic [BL-1:0] mem [MD];

  int n_pass   = 0;
  int n_checks = 0;

  typedef struct {
    int          sa;
    int          wc;
    logic [7:0]  pat;
    bit          rnd;
    int          inject;
    int          exp_n;
    int          exp_first_cyc;
    int          exp_done_cyc;
    int          exp_bubbles;
    int          exp_first_word;
    int          exp_last_word;
  } vec_t;

  typedef struct {
    int n;
    int done_cyc;
    int first_cyc;
    int bubbles;
    int first_word;
    int last_word;
  } res_t;

  vec_t vecs[6];

  always #5 clock = ~clock;

  always @(posedge clock) ramDataOut <= mem[ramAddress];

  bram_stream_reader #(
    .blockLength    (BL),
    .memDepth       (MD),
    .addressBitWidth(AW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .startAddress  (startAddress),
    .wordCount     (wordCount),
    .busy          (busy),
    .done          (done),
    .ramAddress    (ramAddress),
    .ramWriteEnable(ramWriteEnable),
    .ramDataOut    (ramDataOut),
    .outData       (outData),
    .outValid      (outValid),
    .outReady      (outReady)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Issues one command at edge 0 and watches the stream until done (cycle numbers from 1).
  task automatic run_cmd(input int sa, input int wc, input logic [7:0] pat, input bit rnd,
                         input int inject, output res_t r);
    logic [BL-1:0] held;
    logic [AW-1:0] addr0;
    bit            stalled;
    int            ahead, idx;
    r       = '{n: 0, done_cyc: -1, first_cyc: -1, bubbles: 0, first_word: -1, last_word: -1};
    stalled = 0;
    held    = '0;
    addr0   = ramAddress;
    startAddress = AW'(sa);
    wordCount    = (AW + 1)'(wc);
    start        = 1'b1;
    outReady     = 1'b1;
    tick();
    for (int cyc = 1; cyc <= MaxCycles; cyc++) begin
      start = (cyc == inject);
      if (start) begin
        startAddress = AW'(sa + 7);
        wordCount    = (AW + 1)'(3);
      end
      outReady = rnd ? 1'($urandom_range(0, 1)) : pat[cyc % 8];
      if (wc != 0 && wc < int'(MD)) begin
        ahead = int'(AW'(ramAddress - AW'(sa))) - r.n;
        check(ahead <= 2, "addr_ahead", ahead, 2);
      end
      if (outValid) begin
        if (r.first_cyc < 0) begin
          r.first_cyc  = cyc;
          r.first_word = int'(outData);
        end
        if (stalled) check(outData == held, "stall_hold", outData, held);
        if (outReady) begin
          idx = (sa + r.n) % int'(MD);
          check(outData == mem[idx], "word_order", outData, mem[idx]);
          r.last_word = int'(outData);
          r.n++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = outData;
        end
      end else begin
        if (stalled) check(outValid == 1'b1, "valid_held", outValid, 1);
        stalled = 0;
        if (r.first_cyc >= 0 && r.n < wc) r.bubbles++;
      end
      if (done) r.done_cyc = cyc;
      tick();
      if (r.done_cyc >= 0) break;
    end
    start = 1'b0;
    check(r.done_cyc >= 0, "done_seen", r.done_cyc, 0);
    check(busy == 1'b0, "busy_after_done", busy, 0);
    check(r.n == wc, "word_total", r.n, wc);
    if (wc == 0) check(ramAddress == addr0, "zero_len_addr", ramAddress, addr0);
  endtask

  initial begin
    res_t r;
    bit   saw_done, saw_valid;
    int   sa, wc;

    for (int i = 0; i < int'(MD); i++) mem[i] = BL'(i + 100);

    vecs[0] = '{5,  4,  8'hFF, 0, 0, 4,  3,  7,    0,    105,  108};  // basic
    vecs[1] = '{5,  4,  8'h99, 0, 0, 4,  3,  Skip, Skip, 105,  108};  // backpressure 1,0,0,1
    vecs[2] = '{62, 4,  8'hFF, 0, 0, 4,  3,  7,    0,    162,  101};  // wrap-around
    vecs[3] = '{9,  0,  8'hFF, 0, 0, 0,  -1, 1,    0,    Skip, Skip}; // zero length
    vecs[4] = '{20, 6,  8'hFF, 0, 2, 6,  3,  9,    0,    120,  125};  // start ignored mid-run
    vecs[5] = '{10, 64, 8'hFF, 0, 0, 64, 3,  67,   0,    110,  109};  // full depth

    reset        = 1'b1;
    start        = 1'b0;
    startAddress = '0;
    wordCount    = '0;
    outReady     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(done == 1'b0, "rst_done", done, 0);
    check(ramAddress == '0, "rst_addr", ramAddress, 0);
    check(outValid == 1'b0, "rst_valid", outValid, 0);
    check(outData == '0, "rst_data", outData, 0);
    check(ramWriteEnable == 1'b0, "write_enable", ramWriteEnable, 0);

    foreach (vecs[v]) begin
      run_cmd(vecs[v].sa, vecs[v].wc, vecs[v].pat, vecs[v].rnd, vecs[v].inject, r);
      check(r.n == vecs[v].exp_n, "vec_words", r.n, vecs[v].exp_n);
      check(r.first_cyc == vecs[v].exp_first_cyc, "vec_first_valid", r.first_cyc,
            vecs[v].exp_first_cyc);
      if (vecs[v].exp_done_cyc != Skip)
        check(r.done_cyc == vecs[v].exp_done_cyc, "vec_done_cycle", r.done_cyc,
              vecs[v].exp_done_cyc);
      if (vecs[v].exp_bubbles != Skip)
        check(r.bubbles == vecs[v].exp_bubbles, "vec_bubbles", r.bubbles, vecs[v].exp_bubbles);
      if (vecs[v].exp_first_word != Skip)
        check(r.first_word == vecs[v].exp_first_word, "vec_first_word", r.first_word,
              vecs[v].exp_first_word);
      if (vecs[v].exp_last_word != Skip)
        check(r.last_word == vecs[v].exp_last_word, "vec_last_word", r.last_word,
              vecs[v].exp_last_word);
      tick();
    end

    // Reset while two words sit in the FIFO under backpressure.
    startAddress = AW'(30);
    wordCount    = (AW + 1)'(8);
    outReady     = 1'b0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check(outValid == 1'b1, "pre_reset_valid", outValid, 1);
    check(outData == 130, "pre_reset_head", outData, 130);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check(outValid == 1'b0, "mid_rst_valid", outValid, 0);
    check(busy == 1'b0, "mid_rst_busy", busy, 0);
    check(done == 1'b0, "mid_rst_done", done, 0);
    check(ramAddress == '0, "mid_rst_addr", ramAddress, 0);
    saw_done  = 0;
    saw_valid = 0;
    repeat (10) begin
      if (done) saw_done = 1;
      if (outValid) saw_valid = 1;
      tick();
    end
    check(saw_done == 1'b0, "no_done_after_rst", saw_done, 0);
    check(saw_valid == 1'b0, "no_valid_after_rst", saw_valid, 0);
    run_cmd(0, 2, 8'hFF, 0, 0, r);
    check(r.first_word == 100, "post_rst_first", r.first_word, 100);
    check(r.last_word == 101, "post_rst_last", r.last_word, 101);
    check(r.done_cyc == 5, "post_rst_done", r.done_cyc, 5);

    // Random commands with random backpressure.
    for (int k = 0; k < 20; k++) begin
      sa = int'($urandom_range(0, MD - 1));
      wc = int'($urandom_range(0, MD));
      run_cmd(sa, wc, 8'h00, 1, 0, r);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side sequencer placed directly in front of the team's single-port block RAM (registered read, 1-cycle read latency, writeEnable/address/dataIn/dataOut interface).
- On a start command it walks a contiguous, wrapping address range, drives the RAM address, and captures the returned words.
- Captured words are emitted on a valid/ready stream. A 2-entry skid FIFO absorbs the RAM latency so downstream backpressure never loses a word.

Parameters:
- blockLength, 32, RAM word width in bits
- memDepth, 64, number of RAM words; address wrap point
- addressBitWidth, 6, RAM address width; must satisfy 2^addressBitWidth >= memDepth

Ports:
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- startAddress  in  addressBitWidth  first word address; must be < memDepth
- wordCount  in  addressBitWidth+1  words to read, 0..memDepth
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- ramAddress  out  addressBitWidth  registered address to the RAM
- ramWriteEnable  out  1  constant 0; this block never writes
- ramDataOut  in  blockLength  RAM registered read data
- outData  out  blockLength  stream data (FIFO head)
- outValid  out  1  stream valid
- outReady  in  1  stream ready; a word transfers when outValid && outReady

Behaviour:
- Reset state: every register cleared on the rising edge while reset=1.
  - Outputs after reset: busy=0, done=0, ramAddress=0, outValid=0, outData=0.
  - FIFO emptied, in-flight read discarded, FSM in IDLE.
  - Reset during an active command aborts it with no done pulse. A word returning from the RAM after reset is not captured.
- FSM states:
  - IDLE: start=1 latches startAddress and wordCount.
    - wordCount=0: go to DONE; no RAM read, no stream output.
    - Otherwise: go to READ.
    - start=0: stay in IDLE.
  - READ: issue reads until wordCount addresses have been issued, then go to DRAIN.
  - DRAIN: wait until the in-flight read has been captured and the FIFO is empty (last word accepted), then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
  - busy=1 in READ, DRAIN and DONE; busy=0 in IDLE.
  - start is ignored when the FSM is not in IDLE.
- Issue rule:
  - At most one read is issued per cycle.
  - In READ, a read is issued at an edge if (fifoCount + inFlight) < 2, or if a stream pop occurs in that same cycle.
  - Issuing registers ramAddress, sets inFlight=1 for the next cycle and increments issuedCount.
  - The first read uses startAddress, which appears on ramAddress in the first READ cycle.
- Address wrap: the next address is ramAddress+1, except that memDepth-1 wraps to 0. This holds for non-power-of-2 memDepth.
- Capture: the cycle after an issue, ramDataOut holds the word; it is written into the FIFO at that cycle's edge.
- Stream:
  - outValid = (fifoCount != 0). outData is the FIFO head.
  - While outValid=1 and outReady=0, outData and outValid hold stable.
  - Simultaneous push and pop with fifoCount=1 or 2: the count is unchanged and order is preserved.
  - The credit rule guarantees the FIFO never overflows.
- Latency and throughput:
  - start is sampled at edge 0, ramAddress=startAddress in cycle 1, and the word is captured at the edge ending cycle 2.
  - outValid rises in cycle 3.
  - With outReady held at 1: one word per cycle, no bubbles.
  - done occurs 1 cycle after the last transfer.
- Words are delivered in address order, each exactly once.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE, READ, DRAIN, DONE.
  - FIFO depth constant (2).
- One sub-module, bram_skid_fifo: 2-entry synchronous FIFO with blockLength-wide data, push/pop, count, and the same clock/reset.
- Address/credit logic and the FSM stay in the top module.

Test Plan:
- Basic read: RAM preloaded with mem[i]=i+100.
  - Stimulus: start with startAddress=5, wordCount=4, outReady=1.
  - Required: outValid in cycles 3-6 with outData 105, 106, 107, 108; done in cycle 7; busy low in cycle 8.
- Backpressure: same command, outReady toggling 1,0,0,1,…
  - Required: exactly 105..108, in order, no duplicates or drops.
  - Required: outData stable while stalled; ramAddress never runs more than 2 words ahead of accepted words.
- Wrap-around:
  - Stimulus: startAddress=62, wordCount=4, memDepth=64.
  - Required: addresses 62, 63, 0, 1; data 162, 163, 100, 101.
- Zero length:
  - Stimulus: wordCount=0.
  - Required: done pulses one cycle after start, ramAddress unchanged, outValid never asserts.
  - Stimulus: start asserted mid-command with different arguments.
  - Required: ignored; the original stream completes unchanged.
- Reset mid-operation:
  - Stimulus: assert reset for one cycle after 2 of 8 words with outReady=0.
  - Required: the next cycle shows outValid=0, busy=0, done=0, ramAddress=0; no done pulse follows.
  - Then a fresh command (startAddress=0, wordCount=2) returns 100, 101.
- Full depth:
  - Stimulus: wordCount=64, startAddress=10, outReady=1.
  - Required: 64 consecutive words, 110..163 then 100..109, with no bubble after the first word.
